// File: rtl/otp_lock_ctrl_pkg.sv
// otp_lock_ctrl_pkg: state encoding, default OTP and timer-width helper shared by the OTP lock controller
package otp_lock_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_CHECK   = 3'd2,
    S_UNLOCK  = 3'd3,
    S_DENY    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;
  localparam logic [31:0] DEFAULT_OTP = 32'h13579;
  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/otp_lock_ctrl_if.sv
// otp_lock_ctrl_if: keypad-side request/OTP inputs and actuator/alarm outputs; master drives inputs, slave is the controller
interface otp_lock_ctrl_if #(parameter int OTP_W = 32, parameter int TRW = 2);
  logic             req_access;
  logic             enter_otp;
  logic [OTP_W-1:0] user_entered_otp;
  logic             correct;
  logic             wrong;
  logic             unlock;
  logic             deny;
  logic             alarm;
  logic             locked_out;
  logic [TRW-1:0]   tries_left;
  modport master (
    output req_access, enter_otp, user_entered_otp,
    input  correct, wrong, unlock, deny, alarm, locked_out, tries_left
  );
  modport slave (
    input  req_access, enter_otp, user_entered_otp,
    output correct, wrong, unlock, deny, alarm, locked_out, tries_left
  );
endinterface

// File: rtl/otp_lock_ctrl_timer.sv
// otp_cycle_timer: loadable down-counter (clk, rst, load, value, en) that saturates at zero; done=(cnt==0)
module otp_cycle_timer #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= load ? value : (en && cnt != '0) ? cnt - 1'b1 : cnt;
  assign done = cnt == '0;
endmodule

// File: rtl/otp_lock_ctrl.sv
// otp_lock_ctrl: OTP door-lock FSM with entry timeout, bounded retries, timed unlock and alarm lockout; ports clk, rst, bus (otp_lock_ctrl_if.slave), all outputs registered
module otp_lock_ctrl
  import otp_lock_ctrl_pkg::*;
#(
  parameter int               OTP_W          = 32,
  parameter logic [OTP_W-1:0] OTP_VALUE      = OTP_W'(DEFAULT_OTP),
  parameter int               MAX_TRIES      = 3,
  parameter int               ENTRY_TIMEOUT  = 1000,
  parameter int               UNLOCK_CYCLES  = 500,
  parameter int               LOCKOUT_CYCLES = 5000
) (
  input logic             clk,
  input logic             rst,
  otp_lock_ctrl_if.slave  bus
);
  localparam int TW  = timer_w(ENTRY_TIMEOUT, UNLOCK_CYCLES, LOCKOUT_CYCLES);
  localparam int TRW = $clog2(MAX_TRIES + 1);
  state_t           state, nxt;
  logic [TRW-1:0]   fail, fail_nxt, tries_n;
  logic [OTP_W-1:0] otp_q;
  logic             done, load, match, last_try;
  logic [TW-1:0]    load_val;
  logic             correct_n, wrong_n, unlock_n, deny_n, alarm_n;
  assign match    = otp_q == OTP_VALUE;
  assign last_try = int'(fail) + 1 >= MAX_TRIES;
  // Timer is reloaded only on entry to a timed state, so self-loops keep counting down.
  assign load     = nxt != state && (nxt == S_WAIT || nxt == S_UNLOCK || nxt == S_LOCKOUT);
  assign load_val = nxt == S_UNLOCK  ? TW'(UNLOCK_CYCLES - 1) :
                    nxt == S_LOCKOUT ? TW'(LOCKOUT_CYCLES - 1) : TW'(ENTRY_TIMEOUT - 1);
  otp_cycle_timer #(.W(TW)) u_timer (
    .clk(clk), .rst(rst), .load(load), .en(1'b1), .value(load_val), .done(done)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= S_IDLE;
      fail           <= '0;
      otp_q          <= '0;
      bus.correct    <= 1'b0;
      bus.wrong      <= 1'b0;
      bus.unlock     <= 1'b0;
      bus.deny       <= 1'b0;
      bus.alarm      <= 1'b0;
      bus.locked_out <= 1'b0;
      bus.tries_left <= TRW'(MAX_TRIES);
    end else begin
      state          <= nxt;
      fail           <= fail_nxt;
      otp_q          <= state == S_WAIT && bus.enter_otp ? bus.user_entered_otp : otp_q;
      bus.correct    <= correct_n;
      bus.wrong      <= wrong_n;
      bus.unlock     <= unlock_n;
      bus.deny       <= deny_n;
      bus.alarm      <= alarm_n;
      bus.locked_out <= alarm_n;
      bus.tries_left <= tries_n;
    end
  always_comb begin
    nxt      = S_IDLE;
    fail_nxt = fail;
    case (state)
      S_IDLE:    nxt = bus.req_access ? S_WAIT : S_IDLE;
      S_WAIT:    nxt = bus.enter_otp ? S_CHECK : done ? S_IDLE : S_WAIT;
      S_CHECK: begin
        nxt      = match ? S_UNLOCK : last_try ? S_LOCKOUT : S_DENY;
        fail_nxt = match ? '0 : last_try ? fail : fail + 1'b1;
      end
      S_UNLOCK:  nxt = done ? S_IDLE : S_UNLOCK;
      S_DENY:    nxt = S_WAIT;
      S_LOCKOUT: begin
        nxt      = done ? S_IDLE : S_LOCKOUT;
        fail_nxt = done ? '0 : fail;
      end
      default:   fail_nxt = '0;
    endcase
  end
  // Outputs are decoded from the next state so the registered copies line up with the state register.
  always_comb begin
    correct_n = nxt == S_UNLOCK && state == S_CHECK;
    wrong_n   = nxt == S_DENY || (nxt == S_LOCKOUT && state == S_CHECK);
    unlock_n  = nxt == S_UNLOCK;
    deny_n    = nxt == S_DENY;
    alarm_n   = nxt == S_LOCKOUT;
    tries_n   = nxt == S_LOCKOUT ? '0 : TRW'(MAX_TRIES) - fail_nxt;
  end
endmodule
